// File: rtl/cm_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// cm_sweep_ctrl
//
// Exhaustive truth-table sweeper for a 3-input combinational block ("Cm").
// On start it walks {A,B,C} through 000..111. Each vector is held for SETTLE
// cycles, and the response on cm_out is captured into resp_table at the end
// of that hold. When the sweep finishes, done pulses for one cycle and pass
// reports whether the captured table matches EXPECTED.
//
// Parameters
//   SETTLE    cycles each vector is held before sampling (1..15)
//   EXPECTED  golden truth table; bit i = expected cm_out for {A,B,C}=i
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       begin a full sweep (honoured only when idle)
//   abort       cancel the running sweep (honoured only while busy)
//   cm_out      response of the datapath under test
//   A, B, C     registered stimulus (A is the MSB of the vector index)
//   busy        sweep in progress
//   done        one-cycle pulse at sweep completion
//   resp_table  captured responses; bit i = cm_out for vector i
//               ("table" is a reserved word, hence the name)
//   pass        resp_table == EXPECTED; valid from done until the next start
// -----------------------------------------------------------------------------
module cm_sweep_ctrl #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [7:0]  EXPECTED = 8'hD0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       cm_out,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic [7:0] resp_table,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [2:0] idx,   idx_nxt;
    logic [3:0] cnt,   cnt_nxt;
    logic [7:0] tbl_nxt;
    logic       pass_nxt;

    // idx is a register and is forced to 0 whenever the FSM is outside RUN.
    // It therefore serves directly as the registered stimulus.
    assign {A, B, C} = idx;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its peers; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= 4'd0;
            resp_table <= 8'h00;
            pass       <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            resp_table <= tbl_nxt;
            pass       <= pass_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a hold value first, so no
        // path through the case statement can leave one unassigned (no latches).
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        tbl_nxt   = resp_table;
        pass_nxt  = pass;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    idx_nxt   = 3'd0;
                    cnt_nxt   = 4'd0;
                    tbl_nxt   = 8'h00;
                    pass_nxt  = 1'b0;
                end
            end

            RUN: begin
                if (abort) begin
                    // Abort overrides a capture due on the same edge. Bits
                    // already captured stay in resp_table.
                    state_nxt = IDLE;
                    idx_nxt   = 3'd0;
                    cnt_nxt   = 4'd0;
                    pass_nxt  = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    tbl_nxt[idx] = cm_out;
                    cnt_nxt      = 4'd0;
                    idx_nxt      = idx + 3'd1;   // 7 wraps to 0, restoring ABC=000
                    if (idx == 3'd7) begin
                        state_nxt = DONE;
                        // Compare against the table that includes this last capture.
                        pass_nxt  = (tbl_nxt == EXPECTED);
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end

            DONE: state_nxt = IDLE;

            default: begin
                state_nxt = IDLE;
                idx_nxt   = 3'd0;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_cm_sweep_ctrl.sv
module tb_cm_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT with SETTLE=1
    logic       start1, abort1, cm1, cm_zero;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [7:0] tbl1;

    // DUT with SETTLE=3
    logic       start3, abort3, cm3;
    logic       a3, b3, c3, busy3, done3, pass3;
    logic [7:0] tbl3;

    // Reference Cm: out = A & (B | ~C); optionally tied low.
    assign cm1 = cm_zero ? 1'b0 : (a1 & (b1 | ~c1));
    assign cm3 = a3 & (b3 | ~c3);

    cm_sweep_ctrl #(.SETTLE(1), .EXPECTED(8'hD0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .cm_out(cm1),
        .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1),
        .resp_table(tbl1), .pass(pass1)
    );

    cm_sweep_ctrl #(.SETTLE(3), .EXPECTED(8'hD0)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .cm_out(cm3),
        .A(a3), .B(b3), .C(c3), .busy(busy3), .done(done3),
        .resp_table(tbl3), .pass(pass3)
    );

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard of expected tables, pushed at start and popped at done.
    logic [7:0] exp_q[$];

    function automatic logic [7:0] model_table(input bit zero);
        logic [7:0] t;
        logic [2:0] v;
        t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            v    = 3'(i);
            t[i] = zero ? 1'b0 : (v[2] & (v[1] | ~v[0]));
        end
        return t;
    endfunction

    task automatic wait_done1(output int n);
        n = 0;
        while (done1 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start1 = 0; abort1 = 0; start3 = 0; abort3 = 0; cm_zero = 0;
        #1 rst = 1'b1;
        #1;
        compared++;
        if ({a1, b1, c1, busy1, done1, pass1, tbl1} !== 14'h0) begin
            mismatched++;
            $display("FAIL reset_dut1: got abc=%b busy=%b done=%b pass=%b table=%h, want all 0",
                     {a1, b1, c1}, busy1, done1, pass1, tbl1);
        end
        compared++;
        if ({a3, b3, c3, busy3, done3, pass3, tbl3} !== 14'h0) begin
            mismatched++;
            $display("FAIL reset_dut3: got abc=%b busy=%b done=%b pass=%b table=%h, want all 0",
                     {a3, b3, c3}, busy3, done3, pass3, tbl3);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One SETTLE=1 sweep; the caller is at a negedge with the DUT idle.
    task automatic test_sweep1(input bit zero);
        logic [7:0] e;
        cm_zero = zero;
        exp_q.push_back(model_table(zero));
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int v = 0; v < 8; v++) begin
            compared++;
            if ({a1, b1, c1, busy1, done1} !== {3'(v), 2'b10}) begin
                mismatched++;
                $display("FAIL sweep1_step%0d: got abc=%b busy=%b done=%b, want abc=%b busy=1 done=0",
                         v, {a1, b1, c1}, busy1, done1, 3'(v));
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        compared++;
        if ({done1, busy1, tbl1, pass1, a1, b1, c1} !== {2'b10, e, (e == 8'hD0), 3'b000}) begin
            mismatched++;
            $display("FAIL sweep1_done: got done=%b busy=%b table=%h pass=%b abc=%b, want done=1 busy=0 table=%h pass=%b abc=000",
                     done1, busy1, tbl1, pass1, {a1, b1, c1}, e, (e == 8'hD0));
        end
        repeat (2) begin
            @(negedge clk);
            compared++;
            if ({done1, busy1, tbl1, pass1} !== {2'b00, e, (e == 8'hD0)}) begin
                mismatched++;
                $display("FAIL sweep1_idle_hold: got done=%b busy=%b table=%h pass=%b, want done=0 busy=0 table=%h pass=%b",
                         done1, busy1, tbl1, pass1, e, (e == 8'hD0));
            end
        end
    endtask

    task automatic test_settle3;
        logic [7:0] e;
        exp_q.push_back(model_table(1'b0));
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int v = 0; v < 8; v++) begin
            for (int s = 0; s < 3; s++) begin
                compared++;
                if ({a3, b3, c3, busy3, done3} !== {3'(v), 2'b10}) begin
                    mismatched++;
                    $display("FAIL settle3_v%0d_s%0d: got abc=%b busy=%b done=%b, want abc=%b busy=1 done=0",
                             v, s, {a3, b3, c3}, busy3, done3, 3'(v));
                end
                @(negedge clk);
            end
        end
        e = exp_q.pop_front();
        compared++;
        if ({done3, busy3, tbl3, pass3} !== {2'b10, e, 1'b1}) begin
            mismatched++;
            $display("FAIL settle3_done: got done=%b busy=%b table=%h pass=%b, want done=1 busy=0 table=%h pass=1",
                     done3, busy3, tbl3, pass3, e);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        logic [7:0] e;
        cm_zero = 1'b0;
        exp_q.push_back(model_table(1'b0));
        exp_q.push_back(model_table(1'b0));
        start1 = 1'b1;
        wait_done1(n);
        compared++;
        if (n != 9) begin
            mismatched++;
            $display("FAIL b2b_first_latency: got %0d cycles, want 9", n);
        end
        e = exp_q.pop_front();
        compared++;
        if ({tbl1, pass1} !== {e, 1'b1}) begin
            mismatched++;
            $display("FAIL b2b_first_table: got table=%h pass=%b, want table=%h pass=1", tbl1, pass1, e);
        end
        @(negedge clk);
        wait_done1(n);
        compared++;
        if (n + 1 != 10) begin
            mismatched++;
            $display("FAIL b2b_spacing: got %0d cycles between done pulses, want 10", n + 1);
        end
        start1 = 1'b0;
        e = exp_q.pop_front();
        compared++;
        if ({tbl1, pass1} !== {e, 1'b1}) begin
            mismatched++;
            $display("FAIL b2b_second_table: got table=%h pass=%b, want table=%h pass=1", tbl1, pass1, e);
        end
        repeat (2) @(negedge clk);
        compared++;
        if (busy1 !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_no_queue: got busy=%b, want 0", busy1);
        end
    endtask

    task automatic test_abort;
        cm_zero = 1'b0;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        compared++;
        if ({a1, b1, c1, busy1} !== 4'b1001) begin
            mismatched++;
            $display("FAIL abort_setup: got abc=%b busy=%b, want abc=100 busy=1", {a1, b1, c1}, busy1);
        end
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        compared++;
        if ({busy1, done1, pass1, a1, b1, c1, tbl1} !== {6'b000000, 8'h00}) begin
            mismatched++;
            $display("FAIL abort_state: got busy=%b done=%b pass=%b abc=%b table=%h, want busy=0 done=0 pass=0 abc=000 table=00",
                     busy1, done1, pass1, {a1, b1, c1}, tbl1);
        end
        repeat (3) begin
            @(negedge clk);
            compared++;
            if ({busy1, done1} !== 2'b00) begin
                mismatched++;
                $display("FAIL abort_no_done: got busy=%b done=%b, want 0 0", busy1, done1);
            end
        end
    endtask

    task automatic test_reset_midsweep;
        cm_zero = 1'b0;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        compared++;
        if ({a1, b1, c1, busy1, tbl1} !== {4'b1101, 8'h10}) begin
            mismatched++;
            $display("FAIL rstmid_setup: got abc=%b busy=%b table=%h, want abc=110 busy=1 table=10",
                     {a1, b1, c1}, busy1, tbl1);
        end
        #2 rst = 1'b1;
        start1 = 1'b1;
        #1;
        compared++;
        if ({a1, b1, c1, busy1, done1, pass1, tbl1} !== 14'h0) begin
            mismatched++;
            $display("FAIL rstmid_async: got abc=%b busy=%b done=%b pass=%b table=%h, want all 0",
                     {a1, b1, c1}, busy1, done1, pass1, tbl1);
        end
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            compared++;
            if (busy1 !== 1'b0) begin
                mismatched++;
                $display("FAIL rstmid_start_forgotten: got busy=%b, want 0", busy1);
            end
        end
        test_sweep1(1'b0);
    endtask

    initial begin
        test_reset();
        test_sweep1(1'b0);
        test_sweep1(1'b1);
        test_sweep1(1'b1);
        test_settle3();
        test_back_to_back();
        test_abort();
        test_reset_midsweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cm_sweep_ctrl.md
CM_SWEEP_CTRL -- requirements
Module: cm_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, gives the cycles each input vector is held before sampling (legal range 1..15).
REQ-002 Parameter EXPECTED, default 8'hD0, is the golden truth table; bit i is the expected out for {A,B,C}=i, with A as MSB.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a full 8-vector sweep; sampled only in IDLE.
REQ-006 abort  input  1  cancel the sweep in progress; sampled only in RUN.
REQ-007 cm_out  input  1  out of the externally instantiated Cm datapath under test.
REQ-008 A, B, C  output  1 each  registered stimulus driven to the Cm datapath.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 table  output  8  captured responses; bit i holds cm_out for vector i.
REQ-012 pass  output  1  high when table==EXPECTED; valid from done until the next start.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 Internal counters: vector index idx (3 bits) and settle counter cnt (4 bits).
REQ-015 IDLE with start=1 at edge k:
- state becomes RUN, idx=0, cnt=0.
- table and pass cleared to 0.
- {A,B,C}=3'b000.
REQ-016 RUN, {A,B,C} always equals idx.
REQ-017 RUN, cnt<SETTLE-1: cnt increments.
REQ-018 RUN, cnt==SETTLE-1:
- table[idx] is loaded from cm_out.
- cnt returns to 0.
- idx increments.
REQ-019 RUN, idx==7 and cnt==SETTLE-1:
- after the capture, the next state is DONE.
- {A,B,C} returns to 3'b000.
- idx wraps to 0.
REQ-020 Sweep timing for a start accepted at edge k:
- busy is high for cycles k+1 .. k+8*SETTLE.
- DONE occupies cycle k+8*SETTLE+1.
REQ-021 DONE lasts exactly one cycle:
- done=1 and busy=0.
- pass=(table==EXPECTED), registered on entry to DONE.
- next state is IDLE unconditionally.
REQ-022 start is ignored in RUN and DONE; there is no queueing of requests.
REQ-023 abort=1 in RUN:
- next state is IDLE, with no done pulse.
- pass=0; table keeps the bits already captured.
- {A,B,C}=3'b000.
- abort has priority over a capture in the same cycle; that capture does not occur.
REQ-024 abort in IDLE or DONE has no effect.
REQ-025 In IDLE, table and pass hold their last values.
REQ-026 cm_out is treated as combinational from {A,B,C}; it is sampled no earlier than SETTLE cycles after the vector changes.

Reset
REQ-027 rst=1 forces the following immediately, regardless of clk:
- state=IDLE, idx=0, cnt=0.
- A=B=C=0, busy=0, done=0, table=8'h00, pass=0.
REQ-028 Reset mid-sweep discards all progress; the first start after rst falls begins a fresh sweep from vector 0.
REQ-029 A start asserted while rst=1 is not remembered.

Verification
REQ-030 SETTLE=1, correct Cm attached (out=A&(B|~C)), start pulse at edge k:
- {A,B,C} steps 000..111, one vector per cycle.
- done=1 in cycle k+9.
- table=8'hD0, pass=1.
REQ-031 SETTLE=1, cm_out tied to 0:
- table=8'h00 and pass=0 at done.
- a second start clears table and repeats the sweep with identical results.
REQ-032 SETTLE=3, correct Cm:
- each vector is held exactly 3 cycles.
- done=1 in cycle k+25; table=8'hD0, pass=1.
REQ-033 start held high continuously:
- sweeps run back to back, each 8*SETTLE+2 cycles apart.
- start is ignored during RUN and DONE.
REQ-034 SETTLE=1, abort=1 while {A,B,C}=3'b100:
- IDLE on the next cycle, with no done pulse.
- table[3:0]=4'b0000 and table[4] not captured.
- pass=0, {A,B,C}=000.
REQ-035 rst asserted asynchronously while {A,B,C}=3'b110:
- all outputs go to 0 before the next clk edge.
- a subsequent start produces a normal full sweep.
